// File: rtl/cpu_slot_bridge.sv
// Initiator side of the slot req/ack handshake.
// Samples Z80/R800 bus pins in the clk domain and issues exactly one request per CPU strobe.
// The CPU is held in WAIT until the responder acknowledges, or until a cycle timeout forces
// completion. Read data, or the interrupt vector on INTA cycles, is returned to the CPU.
module cpu_slot_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [7:0]  INTA_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        RESET_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_di_oe,
  output logic        cpu_wait_n,
  output logic        req,
  input  logic        ack,
  output logic        mem,
  output logic        wrt,
  output logic [15:0] adr,
  output logic [7:0]  dbo,
  input  logic [7:0]  dbi,
  output logic        timeout
);

  localparam int unsigned   CntW    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StSettle, StIdle, StReq, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic        s_mreq_n_q, s_iorq_n_q, s_rd_n_q, s_wr_n_q, s_m1_n_q;
  logic [15:0] s_a_q;
  logic [7:0]  s_do_q;

  logic        req_q, mem_q, wrt_q, cpu_di_oe_q, cpu_wait_n_q, timeout_q;
  logic [15:0] adr_q;
  logic [7:0]  dbo_q, cpu_di_q;

  logic active, inta;

  assign active = (!s_mreq_n_q || !s_iorq_n_q) && (!s_rd_n_q || !s_wr_n_q);
  assign inta   = !s_m1_n_q && !s_iorq_n_q;

  assign req        = req_q;
  assign mem        = mem_q;
  assign wrt        = wrt_q;
  assign adr        = adr_q;
  assign dbo        = dbo_q;
  assign cpu_di     = cpu_di_q;
  assign cpu_di_oe  = cpu_di_oe_q;
  assign cpu_wait_n = cpu_wait_n_q;
  assign timeout    = timeout_q;

  // Single register stage on all CPU pins. Reset loads a "memory read in progress" pattern so
  // that SETTLE needs a genuinely idle pin sample before arming; a strobe held across reset
  // is therefore never replayed.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      s_mreq_n_q <= 1'b0;
      s_iorq_n_q <= 1'b1;
      s_rd_n_q   <= 1'b0;
      s_wr_n_q   <= 1'b1;
      s_m1_n_q   <= 1'b1;
      s_a_q      <= '0;
      s_do_q     <= '0;
    end else begin
      s_mreq_n_q <= cpu_mreq_n;
      s_iorq_n_q <= cpu_iorq_n;
      s_rd_n_q   <= cpu_rd_n;
      s_wr_n_q   <= cpu_wr_n;
      s_m1_n_q   <= cpu_m1_n;
      s_a_q      <= cpu_a;
      s_do_q     <= cpu_do;
    end
  end

  // Bus-cycle FSM with registered handshake and CPU-side outputs.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= StSettle;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      mem_q        <= 1'b1;
      wrt_q        <= 1'b0;
      adr_q        <= '0;
      dbo_q        <= '0;
      cpu_di_q     <= 8'hFF;
      cpu_di_oe_q  <= 1'b0;
      cpu_wait_n_q <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StSettle: begin
          if (!active && !inta) state_q <= StIdle;
        end
        StIdle: begin
          if (inta) begin
            cpu_di_q    <= INTA_VECTOR;
            cpu_di_oe_q <= 1'b1;
            state_q     <= StDone;
          end else if (active) begin
            // Write wins when both strobes are low.
            req_q        <= 1'b1;
            cpu_wait_n_q <= 1'b0;
            mem_q        <= s_iorq_n_q;
            wrt_q        <= !s_wr_n_q;
            adr_q        <= s_a_q;
            dbo_q        <= s_do_q;
            cnt_q        <= '0;
            state_q      <= StReq;
          end
        end
        StReq: begin
          if (ack) begin
            req_q        <= 1'b0;
            cpu_wait_n_q <= 1'b1;
            if (!wrt_q) begin
              cpu_di_q    <= dbi;
              cpu_di_oe_q <= 1'b1;
            end
            state_q <= StDone;
          end else if (cnt_q == CntLast) begin
            // Nobody answered: release the CPU with open-bus data.
            req_q        <= 1'b0;
            cpu_wait_n_q <= 1'b1;
            timeout_q    <= 1'b1;
            if (!wrt_q) begin
              cpu_di_q    <= 8'hFF;
              cpu_di_oe_q <= 1'b1;
            end
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (!active && !inta) begin
            cpu_di_oe_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StSettle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_slot_bridge.sv
// Directed self-checking bench for cpu_slot_bridge.
module tb_cpu_slot_bridge;

  logic        clk, RESET_n;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do, cpu_di, dbi, dbo;
  logic        cpu_di_oe, cpu_wait_n, req, ack, mem, wrt, timeout;
  logic [15:0] adr;
  logic        ack_comb, ack_r;

  int checks   = 0;
  int failures = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  assign ack = ack_comb ? req : ack_r;

  cpu_slot_bridge #(
    .TIMEOUT_CYC(16),
    .INTA_VECTOR(8'hCF)
  ) dut (
    .clk       (clk),
    .RESET_n   (RESET_n),
    .cpu_mreq_n(cpu_mreq_n),
    .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n  (cpu_rd_n),
    .cpu_wr_n  (cpu_wr_n),
    .cpu_m1_n  (cpu_m1_n),
    .cpu_a     (cpu_a),
    .cpu_do    (cpu_do),
    .cpu_di    (cpu_di),
    .cpu_di_oe (cpu_di_oe),
    .cpu_wait_n(cpu_wait_n),
    .req       (req),
    .ack       (ack),
    .mem       (mem),
    .wrt       (wrt),
    .adr       (adr),
    .dbo       (dbo),
    .dbi       (dbi),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count request pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (req && !req_prev) req_rises++;
    req_prev = req;
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pins_idle();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
  endtask

  // One CPU bus cycle: strobes active 3 clk, then 1 idle clk.
  task automatic bus_cycle(input logic mreq_n, input logic iorq_n, input logic rd_n,
                           input logic wr_n, input logic m1_n, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] rdata);
    dbi = rdata; cpu_a = a; cpu_do = d;
    cpu_mreq_n = mreq_n; cpu_iorq_n = iorq_n; cpu_rd_n = rd_n; cpu_wr_n = wr_n; cpu_m1_n = m1_n;
    cycle(3);
    pins_idle();
    cycle(1);
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    pins_idle();
    cpu_a = 16'h0; cpu_do = 8'h0; dbi = 8'h0; ack_comb = 1'b0; ack_r = 1'b0;
    cycle(1);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", req); end
    checks++; if (mem !== 1'b1) begin failures++; $display("FAIL reset_mem got=%0h exp=1", mem); end
    checks++; if (wrt !== 1'b0) begin failures++; $display("FAIL reset_wrt got=%0h exp=0", wrt); end
    checks++; if (adr !== 16'h0) begin failures++; $display("FAIL reset_adr got=%0h exp=0", adr); end
    checks++; if (dbo !== 8'h0) begin failures++; $display("FAIL reset_dbo got=%0h exp=0", dbo); end
    checks++; if (cpu_di !== 8'hFF) begin failures++; $display("FAIL reset_di got=%0h exp=ff", cpu_di); end
    checks++; if (cpu_di_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%0h exp=0", cpu_di_oe); end
    checks++; if (cpu_wait_n !== 1'b1) begin failures++; $display("FAIL reset_wait got=%0h exp=1", cpu_wait_n); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0h exp=0", timeout); end
    RESET_n = 1'b1;
    cycle(3);
  endtask

  task automatic test_io_write();
    int r0;
    ack_comb = 1'b1;
    r0 = req_rises;
    cpu_a = 16'h00E4; cpu_do = 8'h06; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    cycle(1);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL iow_req_early got=%0h exp=0", req); end
    cycle(1);
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL iow_req_rise got=%0h exp=1", req); end
    checks++; if (cpu_wait_n !== 1'b0) begin failures++; $display("FAIL iow_wait_low got=%0h exp=0", cpu_wait_n); end
    checks++; if (mem !== 1'b0) begin failures++; $display("FAIL iow_mem got=%0h exp=0", mem); end
    checks++; if (wrt !== 1'b1) begin failures++; $display("FAIL iow_wrt got=%0h exp=1", wrt); end
    checks++; if (adr !== 16'h00E4) begin failures++; $display("FAIL iow_adr got=%0h exp=00e4", adr); end
    checks++; if (dbo !== 8'h06) begin failures++; $display("FAIL iow_dbo got=%0h exp=06", dbo); end
    cycle(1);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL iow_req_width got=%0h exp=0", req); end
    checks++; if (cpu_wait_n !== 1'b1) begin failures++; $display("FAIL iow_wait_rel got=%0h exp=1", cpu_wait_n); end
    checks++; if (cpu_di_oe !== 1'b0) begin failures++; $display("FAIL iow_oe got=%0h exp=0", cpu_di_oe); end
    cycle(5);
    checks++; if (req_rises - r0 !== 1) begin failures++; $display("FAIL iow_req_count got=%0d exp=1", req_rises - r0); end
    pins_idle();
    cycle(3);
  endtask

  task automatic test_mem_read();
    int hi, lo;
    ack_comb = 1'b0; ack_r = 1'b0; dbi = 8'h3E;
    cpu_a = 16'h1234; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    cycle(2);
    hi = 0; lo = 0;
    for (int i = 0; i < 6; i++) begin
      if (req) hi++;
      if (!cpu_wait_n) lo++;
      if (i < 5) cycle(1);
    end
    ack_r = 1'b1;
    cycle(1);
    ack_r = 1'b0;
    checks++; if (hi !== 6) begin failures++; $display("FAIL mrd_req_width got=%0d exp=6", hi); end
    checks++; if (lo !== 6) begin failures++; $display("FAIL mrd_wait_width got=%0d exp=6", lo); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL mrd_req_fall got=%0h exp=0", req); end
    checks++; if (cpu_wait_n !== 1'b1) begin failures++; $display("FAIL mrd_wait_rel got=%0h exp=1", cpu_wait_n); end
    checks++; if (cpu_di !== 8'h3E) begin failures++; $display("FAIL mrd_di got=%0h exp=3e", cpu_di); end
    checks++; if (mem !== 1'b1 || wrt !== 1'b0) begin failures++; $display("FAIL mrd_memwrt got=%0h%0h exp=10", mem, wrt); end
    cycle(3);
    checks++; if (cpu_di_oe !== 1'b1) begin failures++; $display("FAIL mrd_oe_hold got=%0h exp=1", cpu_di_oe); end
    pins_idle();
    cycle(1);
    checks++; if (cpu_di_oe !== 1'b1) begin failures++; $display("FAIL mrd_oe_plus1 got=%0h exp=1", cpu_di_oe); end
    cycle(1);
    checks++; if (cpu_di_oe !== 1'b0) begin failures++; $display("FAIL mrd_oe_drop got=%0h exp=0", cpu_di_oe); end
    cycle(1);
  endtask

  task automatic test_timeout();
    int hi;
    ack_comb = 1'b0; ack_r = 1'b0; dbi = 8'h00;
    cpu_a = 16'h8000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    cycle(2);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!req) break;
      hi++;
      cycle(1);
    end
    checks++; if (hi !== 16) begin failures++; $display("FAIL to_req_width got=%0d exp=16", hi); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%0h exp=1", timeout); end
    checks++; if (cpu_di !== 8'hFF) begin failures++; $display("FAIL to_di got=%0h exp=ff", cpu_di); end
    checks++; if (cpu_di_oe !== 1'b1) begin failures++; $display("FAIL to_oe got=%0h exp=1", cpu_di_oe); end
    checks++; if (cpu_wait_n !== 1'b1) begin failures++; $display("FAIL to_wait got=%0h exp=1", cpu_wait_n); end
    cycle(1);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%0h exp=0", timeout); end
    pins_idle();
    cycle(3);
  endtask

  task automatic test_ack_at_limit();
    ack_comb = 1'b0; ack_r = 1'b0; dbi = 8'h5A;
    cpu_a = 16'h4000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    cycle(2);
    cycle(15);
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL lim_req_held got=%0h exp=1", req); end
    ack_r = 1'b1;
    cycle(1);
    ack_r = 1'b0;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL lim_req_fall got=%0h exp=0", req); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL lim_no_timeout got=%0h exp=0", timeout); end
    checks++; if (cpu_di !== 8'h5A) begin failures++; $display("FAIL lim_di got=%0h exp=5a", cpu_di); end
    pins_idle();
    cycle(3);
  endtask

  task automatic test_refresh_inta();
    int r0;
    ack_comb = 1'b1;
    r0 = req_rises;
    cpu_a = 16'h007F; cpu_mreq_n = 1'b0;
    cycle(5);
    pins_idle();
    cycle(2);
    checks++; if (req_rises - r0 !== 0) begin failures++; $display("FAIL rfsh_no_req got=%0d exp=0", req_rises - r0); end
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    cycle(2);
    checks++; if (cpu_di !== 8'hCF) begin failures++; $display("FAIL inta_di got=%0h exp=cf", cpu_di); end
    checks++; if (cpu_di_oe !== 1'b1) begin failures++; $display("FAIL inta_oe got=%0h exp=1", cpu_di_oe); end
    cycle(2);
    checks++; if (req_rises - r0 !== 0) begin failures++; $display("FAIL inta_no_req got=%0d exp=0", req_rises - r0); end
    checks++; if (cpu_wait_n !== 1'b1) begin failures++; $display("FAIL inta_wait got=%0h exp=1", cpu_wait_n); end
    pins_idle();
    cycle(2);
    checks++; if (cpu_di_oe !== 1'b0) begin failures++; $display("FAIL inta_oe_drop got=%0h exp=0", cpu_di_oe); end
    cycle(1);
  endtask

  task automatic test_reset_mid();
    int r0;
    ack_comb = 1'b0; ack_r = 1'b0;
    cpu_a = 16'hC000; cpu_do = 8'hAA; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    cycle(2);
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL rst_pre_req got=%0h exp=1", req); end
    #1 RESET_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL rst_async_req got=%0h exp=0", req); end
    checks++; if (cpu_wait_n !== 1'b1) begin failures++; $display("FAIL rst_async_wait got=%0h exp=1", cpu_wait_n); end
    cycle(1);
    RESET_n = 1'b1;
    ack_comb = 1'b1;
    r0 = req_rises;
    cycle(6);
    pins_idle();
    cycle(3);
    checks++; if (req_rises - r0 !== 0) begin failures++; $display("FAIL rst_no_replay got=%0d exp=0", req_rises - r0); end
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    cycle(2);
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL rst_rearm got=%0h exp=1", req); end
    pins_idle();
    cycle(3);
  endtask

  task automatic test_back_to_back();
    int r0;
    logic [15:0] pc;
    logic [7:0]  port, val;
    ack_comb = 1'b1;
    r0 = req_rises;
    pc = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      port = (i % 2 == 0) ? 8'hE4 : 8'hE5;
      val  = 8'h10 + 8'(i * 7);
      bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, pc, 8'h00, 8'h3E);
      bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, pc + 16'd1, 8'h00, val);
      checks++; if (cpu_di !== val) begin failures++; $display("FAIL b2b_ld_di[%0d] got=%0h exp=%0h", i, cpu_di, val); end
      bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, pc + 16'd2, 8'h00, 8'hD3);
      bus_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, pc + 16'd3, 8'h00, port);
      bus_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, {val, port}, val, 8'h00);
      checks++; if (adr !== {val, port}) begin failures++; $display("FAIL b2b_adr[%0d] got=%0h exp=%0h", i, adr, {val, port}); end
      checks++; if (dbo !== val) begin failures++; $display("FAIL b2b_dbo[%0d] got=%0h exp=%0h", i, dbo, val); end
      checks++; if (mem !== 1'b0 || wrt !== 1'b1) begin failures++; $display("FAIL b2b_memwrt[%0d] got=%0h%0h exp=01", i, mem, wrt); end
      pc = pc + 16'd4;
    end
    cycle(2);
    checks++; if (req_rises - r0 !== 50) begin failures++; $display("FAIL b2b_req_count got=%0d exp=50", req_rises - r0); end
  endtask

  initial begin
    test_reset();
    test_io_write();
    test_mem_read();
    test_timeout();
    test_ack_at_limit();
    test_refresh_inta();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
